bus_dma_arbiter: RTL and testbench

BUS_DMA_ARBITER -- requirements
Module: bus_dma_arbiter

---
 rtl/bus_dma_arbiter.sv | 114 +++++++++++
 tb/tb_bus_dma_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_arbiter.sv
// Bus DMA arbiter: on a core write to TRIG_ADDR, stalls the core and copies
// 256 bytes from page {PAGE,00..FF} to DEST_ADDR via interleaved READ/WRITE.
module bus_dma_arbiter #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic        PHI0,
  input  logic        RES,
  input  logic [15:0] CPU_A,
  input  logic        CPU_RnW,
  input  logic [7:0]  CPU_DO,
  input  logic [7:0]  DI,
  output logic        RDY,
  output logic [15:0] A,
  output logic        RnW,
  output logic [7:0]  DO,
  output logic        BUSY,
  output logic        PAR
);

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] S_HALT  = 3'd1;
  localparam logic [ST_W-1:0] S_ALIGN = 3'd2;
  localparam logic [ST_W-1:0] S_READ  = 3'd3;
  localparam logic [ST_W-1:0] S_WRITE = 3'd4;

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic [7:0]      page;
  logic [7:0]      idx;
  logic [7:0]      data;
  logic            par;
  logic            trig_c;

  // A trigger is only honoured while idle; writes during a transfer are ignored
  assign trig_c = (state == S_IDLE) && (CPU_A == TRIG_ADDR) && !CPU_RnW;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trig_c) state_nxt = S_HALT;
      // Wait for the core to stall on a read; READ must land on an even cycle
      S_HALT:  if (CPU_RnW) state_nxt = par ? S_READ : S_ALIGN;
      S_ALIGN: state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = (idx == 8'hFF) ? S_IDLE : S_READ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and cycle-parity registers
  always_ff @(posedge PHI0) begin
    if (RES) begin
      state <= S_IDLE;
      par   <= 1'b0;
    end else begin
      state <= state_nxt;
      par   <= ~par;
    end
  end

  // Transfer datapath: source page, byte index and the byte in flight
  always_ff @(posedge PHI0) begin
    if (RES) begin
      page <= 8'h00;
      idx  <= 8'h00;
      data <= 8'h00;
    end else begin
      if (trig_c) begin
        page <= CPU_DO;
        idx  <= 8'h00;
      end
      if (state == S_READ)  data <= DI;
      if (state == S_WRITE) idx  <= idx + 8'd1;
    end
  end

  // Bus mux: core passes through unless the DMA owns the cycle; reset forces pass-through
  always_comb begin
    RDY  = 1'b1;
    A    = CPU_A;
    RnW  = CPU_RnW;
    DO   = CPU_DO;
    BUSY = 1'b0;
    if (!RES) begin
      BUSY = (state != S_IDLE);
      case (state)
        S_HALT: RDY = 1'b0;
        S_ALIGN: begin
          RDY = 1'b0;
          RnW = 1'b1;
        end
        S_READ: begin
          RDY = 1'b0;
          A   = {page, idx};
          RnW = 1'b1;
        end
        S_WRITE: begin
          RDY = 1'b0;
          A   = DEST_ADDR;
          RnW = 1'b0;
          DO  = data;
        end
        default: ;
      endcase
    end
  end

  assign PAR = par;

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Self-checking bench for bus_dma_arbiter: idle vector table plus transfer
// sequences with a write scoreboard fed from the read phase.
module tb_bus_dma_arbiter;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;
  localparam logic [15:0] HOLD = 16'h8123;

  logic        PHI0 = 1'b0;
  logic        RES;
  logic [15:0] CPU_A;
  logic        CPU_RnW;
  logic [7:0]  CPU_DO;
  logic [7:0]  DI;
  logic        RDY;
  logic [15:0] A;
  logic        RnW;
  logic [7:0]  DO;
  logic        BUSY;
  logic        PAR;

  bus_dma_arbiter dut (
    .PHI0(PHI0), .RES(RES), .CPU_A(CPU_A), .CPU_RnW(CPU_RnW), .CPU_DO(CPU_DO),
    .DI(DI), .RDY(RDY), .A(A), .RnW(RnW), .DO(DO), .BUSY(BUSY), .PAR(PAR)
  );

  always #5 PHI0 = ~PHI0;

  typedef struct {
    logic        res;
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  dout;
    logic        exp_rdy;
    logic        exp_busy;
    logic [15:0] exp_a;
    logic        exp_rnw;
    logic [7:0]  exp_do;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  vec_t vecs[8];
  wr_t  sb_q[$];

  int   tests = 0;
  int   fails = 0;
  int   rdy_low = 0;
  logic par_exp = 1'b0;
  bit   par_known = 1'b0;

  logic        s_rdy, s_busy, s_rnw, s_par;
  logic [15:0] s_a;
  logic [7:0]  s_do;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One PHI0 cycle: drive, sample at negedge, advance past the posedge
  task automatic step(input logic res, input logic [15:0] a, input logic rnw, input logic [7:0] dout);
    RES = res; CPU_A = a; CPU_RnW = rnw; CPU_DO = dout;
    @(negedge PHI0);
    s_rdy = RDY; s_busy = BUSY; s_a = A; s_rnw = RnW; s_do = DO; s_par = PAR;
    if (par_known) chk("par", 32'(s_par), 32'(par_exp));
    if (s_rdy == 1'b0) rdy_low++;
    @(posedge PHI0);
    #1;
    if (res) begin
      par_exp   = 1'b0;
      par_known = 1'b1;
    end else begin
      par_exp = ~par_exp;
    end
  endtask

  task automatic expect_out(input string nm, input logic rdy, input logic busy,
                            input logic [15:0] a, input logic rnw, input logic [7:0] dout,
                            input bit chk_do);
    chk({nm, "_rdy"},  32'(s_rdy),  32'(rdy));
    chk({nm, "_busy"}, 32'(s_busy), 32'(busy));
    chk({nm, "_a"},    32'(s_a),    32'(a));
    chk({nm, "_rnw"},  32'(s_rnw),  32'(rnw));
    if (chk_do) chk({nm, "_do"}, 32'(s_do), 32'(dout));
  endtask

  task automatic idle_step(input logic [15:0] a);
    step(1'b0, a, 1'b1, 8'h3C);
    expect_out("idle", 1'b1, 1'b0, a, 1'b1, 8'h3C, 1'b1);
  endtask

  // Full transfer; align_pref: 1 force ALIGN, 0 force aligned, -1 as it comes
  task automatic do_transfer(input logic [7:0] pg, input int align_pref, input int hw,
                             input int retrig_k, input int abort_k);
    logic ph;
    logic align;
    wr_t  e;
    int   exp_low;
    if (align_pref >= 0) begin
      ph = par_exp ^ 1'((hw + 1) % 2);
      if ((ph == 1'b0) != (align_pref == 1)) idle_step(16'h0000);
    end
    DI = 8'($urandom);
    step(1'b0, TRIG, 1'b0, pg);
    expect_out("trig", 1'b1, 1'b0, TRIG, 1'b0, pg, 1'b1);
    rdy_low = 0;
    for (int i = 0; i < hw; i++) begin
      step(1'b0, 16'h0300 + 16'(i), 1'b0, 8'hC0 + 8'(i));
      expect_out("halt_wr", 1'b0, 1'b1, 16'h0300 + 16'(i), 1'b0, 8'hC0 + 8'(i), 1'b1);
    end
    align = ~par_exp;
    step(1'b0, HOLD, 1'b1, 8'h00);
    expect_out("halt_rd", 1'b0, 1'b1, HOLD, 1'b1, 8'h00, 1'b1);
    if (align) begin
      step(1'b0, HOLD, 1'b1, 8'h00);
      expect_out("align", 1'b0, 1'b1, HOLD, 1'b1, 8'h00, 1'b1);
    end
    for (int k = 0; k < 256; k++) begin
      if (k == abort_k) begin
        step(1'b1, HOLD, 1'b1, 8'h5E);
        expect_out("abort", 1'b1, 1'b0, HOLD, 1'b1, 8'h5E, 1'b1);
        sb_q.delete();
        for (int i = 0; i < 12; i++) idle_step(16'h1000 + 16'(i));
        return;
      end
      DI = 8'(k) ^ 8'hA5;
      if (k == retrig_k) step(1'b0, TRIG, 1'b0, 8'h07);
      else               step(1'b0, HOLD, 1'b1, 8'h00);
      expect_out("read", 1'b0, 1'b1, {pg, 8'(k)}, 1'b1, 8'h00, 1'b0);
      chk("read_par", 32'(s_par), 32'd0);
      sb_q.push_back('{DEST, 8'(k) ^ 8'hA5});
      DI = 8'($urandom);
      step(1'b0, HOLD, 1'b1, 8'h00);
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL write_sb: got empty scoreboard, expected one entry");
      end else begin
        e = sb_q.pop_front();
        expect_out("write", 1'b0, 1'b1, e.a, 1'b0, e.d, 1'b1);
      end
    end
    exp_low = 513 + hw + (align ? 1 : 0);
    chk("rdy_low_cycles", 32'(rdy_low), 32'(exp_low));
  endtask

  initial begin
    RES = 1'b1; CPU_A = 16'h0000; CPU_RnW = 1'b1; CPU_DO = 8'h00; DI = 8'h00;

    vecs[0] = '{1'b1, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 16'h1234, 1'b1, 8'h5A, 1'b1, 1'b0, 16'h1234, 1'b1, 8'h5A};
    vecs[2] = '{1'b0, 16'h4014, 1'b1, 8'h33, 1'b1, 1'b0, 16'h4014, 1'b1, 8'h33};
    vecs[3] = '{1'b0, 16'h4015, 1'b0, 8'h44, 1'b1, 1'b0, 16'h4015, 1'b0, 8'h44};
    vecs[4] = '{1'b1, 16'h4014, 1'b0, 8'h01, 1'b1, 1'b0, 16'h4014, 1'b0, 8'h01};
    vecs[5] = '{1'b0, 16'h2004, 1'b0, 8'h99, 1'b1, 1'b0, 16'h2004, 1'b0, 8'h99};
    vecs[6] = '{1'b0, 16'h4013, 1'b0, 8'h11, 1'b1, 1'b0, 16'h4013, 1'b0, 8'h11};
    vecs[7] = '{1'b0, 16'hFFFF, 1'b1, 8'hFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 8'hFF};

    step(1'b1, 16'h0000, 1'b1, 8'h00);
    expect_out("reset", 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b1);

    // Idle pass-through and non-trigger cases
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].res, vecs[i].a, vecs[i].rnw, vecs[i].dout);
      expect_out($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_busy,
                 vecs[i].exp_a, vecs[i].exp_rnw, vecs[i].exp_do, 1'b1);
    end

    do_transfer(8'h02, 0, 0, -1, -1);
    idle_step(16'h0555);
    do_transfer(8'h02, 1, 0, -1, -1);
    idle_step(16'h0556);
    do_transfer(8'h35, -1, 2, -1, -1);
    idle_step(16'h0557);
    do_transfer(8'h5C, -1, 0, 8'h10, 8'h40);
    do_transfer(8'hFF, -1, 0, -1, -1);
    do_transfer(8'h01, -1, 0, -1, -1);
    idle_step(16'h0558);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
